// File: rtl/cal_hu_moment_acc.sv
// Streaming raw-moment accumulator (m00, m10, m01) for the CAL_Hu moment chain.
// Pixels flow through a 4-stage p*x / p*y pipeline; the frame result is held behind valid/ready.
module cal_hu_moment_acc #(
  parameter int PIX_W   = 8,
  parameter int COORD_W = 14,
  parameter int ACC_W   = 52
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ce,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [PIX_W-1:0]   s_pix,
  input  logic               s_eol,
  input  logic               s_eof,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [ACC_W-1:0]   m00,
  output logic [ACC_W-1:0]   m10,
  output logic [ACC_W-1:0]   m01,
  output logic               err
);

  localparam int PROD_W = PIX_W + COORD_W;
  localparam logic [COORD_W-1:0] C_MAX = '1;
  localparam logic [COORD_W-1:0] C_ONE = COORD_W'(1);

  typedef enum logic [1:0] {ACCUM, DRAIN, DONE} state_t;

  state_t             state, state_nxt;
  logic               started;
  logic [2:0]         drain_cnt;
  logic [COORD_W-1:0] x_q, y_q;
  logic               accept, hs, eol_any;

  logic               vld_p1, vld_p2, vld_p3, vld_p4;
  logic [PIX_W-1:0]   pix_p1, pix_p2, pix_p3, pix_p4;
  logic [COORD_W-1:0] x_p1, y_p1, x_p2, y_p2;
  logic [PROD_W-1:0]  px_p3, py_p3, px_p4, py_p4;

  assign s_ready = started && (state == ACCUM);
  assign m_valid = (state == DONE);
  assign accept  = ce && s_valid && s_ready;
  assign hs      = ce && m_valid && m_ready;
  assign eol_any = s_eol || s_eof;

  // The eof product needs four more edges to reach the accumulator; the count of 4 lands DONE on edge five.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ACCUM:   if (accept && s_eof) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == 3'd4) state_nxt = DONE;
      DONE:    if (m_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ACCUM;
      started   <= 1'b0;
      drain_cnt <= 3'd0;
    end else if (ce) begin
      state     <= state_nxt;
      started   <= 1'b1;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 3'd1 : 3'd0;
    end
  end

  // Coordinate tracking; an overflowing coordinate saturates and flags err for the frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q <= '0;
      y_q <= '0;
      err <= 1'b0;
    end else if (ce) begin
      if (accept) begin
        if (eol_any)           x_q <= '0;
        else if (x_q == C_MAX) err <= 1'b1;
        else                   x_q <= x_q + C_ONE;
        if (s_eof)             y_q <= '0;
        else if (s_eol) begin
          if (y_q == C_MAX)    err <= 1'b1;
          else                 y_q <= y_q + C_ONE;
        end
      end else if (hs) begin
        err <= 1'b0;
      end
    end
  end

  // Pipeline valid bits and accumulators
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
      vld_p4 <= 1'b0;
      m00    <= '0;
      m10    <= '0;
      m01    <= '0;
    end else if (ce) begin
      vld_p1 <= accept;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
      vld_p4 <= vld_p3;
      if (hs) begin
        m00 <= '0;
        m10 <= '0;
        m01 <= '0;
      end else if (vld_p4) begin
        m00 <= m00 + ACC_W'(pix_p4);
        m10 <= m10 + ACC_W'(px_p4);
        m01 <= m01 + ACC_W'(py_p4);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ce) begin
      // stage 1: input capture
      pix_p1 <= s_pix;
      x_p1   <= x_q;
      y_p1   <= y_q;
      // stage 2: operand registers
      pix_p2 <= pix_p1;
      x_p2   <= x_p1;
      y_p2   <= y_p1;
      // stage 3: products
      pix_p3 <= pix_p2;
      px_p3  <= PROD_W'(pix_p2) * PROD_W'(x_p2);
      py_p3  <= PROD_W'(pix_p2) * PROD_W'(y_p2);
      // stage 4: output register
      pix_p4 <= pix_p3;
      px_p4  <= px_p3;
      py_p4  <= py_p3;
    end
  end

endmodule

// File: tb/tb_cal_hu_moment_acc.sv
// Randomised bench for cal_hu_moment_acc: two instances (COORD_W 14 and 4) share stimulus
// and are compared against a frame-level moment model.
module tb_cal_hu_moment_acc;
  localparam int PIX_W = 8;
  localparam int ACC_W = 52;
  localparam int CW_A  = 14;
  localparam int CW_B  = 4;

  logic clk = 1'b0;
  logic reset, ce, s_valid, s_eol, s_eof, m_ready;
  logic [PIX_W-1:0] s_pix;
  logic s_ready_a, m_valid_a, err_a, s_ready_b, m_valid_b, err_b;
  logic [ACC_W-1:0] m00_a, m10_a, m01_a, m00_b, m10_b, m01_b;

  int nvec = 0;
  int nerr = 0;

  typedef struct { int p; bit eol; bit eof; } pix_t;
  pix_t frm[$];

  always #5 clk = ~clk;

  cal_hu_moment_acc #(.PIX_W(PIX_W), .COORD_W(CW_A), .ACC_W(ACC_W)) dut_a (
    .clk(clk), .reset(reset), .ce(ce), .s_valid(s_valid), .s_ready(s_ready_a),
    .s_pix(s_pix), .s_eol(s_eol), .s_eof(s_eof), .m_valid(m_valid_a), .m_ready(m_ready),
    .m00(m00_a), .m10(m10_a), .m01(m01_a), .err(err_a));

  cal_hu_moment_acc #(.PIX_W(PIX_W), .COORD_W(CW_B), .ACC_W(ACC_W)) dut_b (
    .clk(clk), .reset(reset), .ce(ce), .s_valid(s_valid), .s_ready(s_ready_b),
    .s_pix(s_pix), .s_eol(s_eol), .s_eof(s_eof), .m_valid(m_valid_b), .m_ready(m_ready),
    .m00(m00_b), .m10(m10_b), .m01(m01_b), .err(err_b));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Frame-level moments: walk accepted pixels in raster order, coordinates clamp at 2^cw-1.
  task automatic model(input int cw, output longint e00, output longint e10,
                       output longint e01, output bit eerr);
    longint x = 0, y = 0, mx;
    mx = (longint'(1) << cw) - 1;
    e00 = 0; e10 = 0; e01 = 0; eerr = 1'b0;
    foreach (frm[i]) begin
      e00 += frm[i].p;
      e10 += frm[i].p * x;
      e01 += frm[i].p * y;
      if (frm[i].eof) begin x = 0; y = 0; end
      else if (frm[i].eol) begin
        x = 0;
        if (y == mx) eerr = 1'b1; else y++;
      end else if (x == mx) eerr = 1'b1;
      else x++;
    end
    e00 &= (longint'(1) << ACC_W) - 1;
    e10 &= (longint'(1) << ACC_W) - 1;
    e01 &= (longint'(1) << ACC_W) - 1;
  endtask

  // mode 0: raster-sequential values 1,2,3..; mode 1: constant val; mode 2: random
  task automatic build(input int w, input int h, input int mode, input int val);
    pix_t e;
    frm.delete();
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        e.p   = (mode == 0) ? r * w + c + 1 : (mode == 1) ? val : int'($urandom_range(255));
        e.eol = (c == w - 1);
        e.eof = (r == h - 1) && (c == w - 1);
        frm.push_back(e);
      end
  endtask

  task automatic run_frame(input string tag, input int gap_pct, input bit ce_tog, input int hold);
    int idx = 0, cyc = 0, n = 0, rdy_bad = 0, hold_bad = 0;
    bit rdy, got = 1'b0;
    longint a00, a10, a01, b00, b10, b01;
    bit aerr, berr;
    model(CW_A, a00, a10, a01, aerr);
    model(CW_B, b00, b10, b01, berr);
    while (idx < frm.size() && cyc < 5000) begin
      @(negedge clk);
      ce      = ce_tog ? ~ce : 1'b1;
      s_valid = ($urandom_range(99) >= gap_pct);
      s_pix   = PIX_W'(frm[idx].p);
      s_eol   = frm[idx].eol;
      s_eof   = frm[idx].eof;
      m_ready = 1'($urandom_range(1));
      rdy     = s_ready_a;
      @(posedge clk);
      if (s_valid && ce && rdy) idx++;
      cyc++;
    end
    check({tag, ".frame_sent"}, idx, frm.size());
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      s_valid = 1'b0;
      if (m_valid_a) got = 1'b1;
      else begin
        if (s_ready_a || s_ready_b) rdy_bad++;
        ce = ce_tog ? ~ce : 1'b1;
        m_ready = 1'($urandom_range(1));
        @(posedge clk);
        if (ce) n++;
      end
    end
    check({tag, ".eof_to_valid_edges"}, n, 5);
    check({tag, ".drain_s_ready_high"}, rdy_bad, 0);
    check({tag, ".b.m_valid"}, m_valid_b, 1);
    check({tag, ".a.m00"}, m00_a, a00);
    check({tag, ".a.m10"}, m10_a, a10);
    check({tag, ".a.m01"}, m01_a, a01);
    check({tag, ".a.err"}, err_a, aerr);
    check({tag, ".b.m00"}, m00_b, b00);
    check({tag, ".b.m10"}, m10_b, b10);
    check({tag, ".b.m01"}, m01_b, b01);
    check({tag, ".b.err"}, err_b, berr);
    // m_ready only ever high while ce is low, so no handshake may complete here
    for (int k = 0; k < hold; k++) begin
      ce      = 1'($urandom_range(1));
      m_ready = ~ce;
      @(posedge clk);
      @(negedge clk);
      if (!m_valid_a || s_ready_a || m00_a !== a00[ACC_W-1:0] || m10_a !== a10[ACC_W-1:0] ||
          m01_a !== a01[ACC_W-1:0] || err_a !== aerr || !m_valid_b || m10_b !== b10[ACC_W-1:0])
        hold_bad++;
    end
    if (hold > 0) check({tag, ".hold_stable"}, hold_bad, 0);
    ce = 1'b1;
    m_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    m_ready = 1'b0;
    check({tag, ".post_hs.m_valid"}, m_valid_a, 0);
    check({tag, ".post_hs.s_ready"}, s_ready_a, 1);
    check({tag, ".post_hs.m00"}, m00_a, 0);
    check({tag, ".post_hs.err_b"}, err_b, 0);
  endtask

  initial begin
    int idx, cyc;
    bit rdy;
    reset = 1'b0; ce = 1'b1; s_valid = 1'b0; s_pix = '0; s_eol = 1'b0; s_eof = 1'b0;
    m_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.s_ready", s_ready_a, 0);
    check("rst.m_valid", m_valid_a, 0);
    check("rst.m00", m00_a, 0);
    check("rst.err", err_a, 0);
    reset = 1'b1;
    @(negedge clk);
    check("rst.s_ready_rise", s_ready_a, 1);

    build(3, 2, 0, 0); run_frame("f3x2", 0, 1'b0, 0);
    build(3, 2, 0, 0); run_frame("f3x2_hold", 0, 1'b0, 10);
    build(1, 1, 1, 7); run_frame("single7", 0, 1'b0, 0);
    build(3, 2, 0, 0); run_frame("f3x2_ce", 0, 1'b1, 4);
    build(17, 1, 1, 1); run_frame("xovf", 0, 1'b0, 0);
    build(1, 18, 1, 1); run_frame("yovf", 20, 1'b0, 0);

    // abort a frame after two pixels with an asynchronous reset
    build(3, 2, 0, 0);
    idx = 0; cyc = 0;
    while (idx < 2 && cyc < 50) begin
      @(negedge clk);
      ce = 1'b1; s_valid = 1'b1; s_pix = PIX_W'(frm[idx].p + 40);
      s_eol = frm[idx].eol; s_eof = frm[idx].eof;
      rdy = s_ready_a;
      @(posedge clk);
      if (rdy) idx++;
      cyc++;
    end
    @(negedge clk);
    s_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("midrst.s_ready", s_ready_a, 0);
    check("midrst.m_valid", m_valid_b, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst.s_ready_rise", s_ready_a, 1);
    run_frame("after_rst", 0, 1'b0, 0);

    build(2, 2, 1, 255); run_frame("f255", 0, 1'b0, 0);
    build(2, 2, 1, 255); run_frame("f255_gaps", 40, 1'b0, 3);

    for (int t = 0; t < 6; t++) begin
      build(int'($urandom_range(20, 1)), int'($urandom_range(4, 1)), 2, 0);
      if ($urandom_range(1) == 1) frm[frm.size() - 1].eol = 1'b0;
      run_frame($sformatf("rand%0d", t), 30, 1'(t % 2), 2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
